seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
- Multi-cycle FSM that sequences the sequential RV64 core through IF, ID, EX, MEM and WB, one stage per cycle or more.
- Latches the fetched instruction, decodes the opcode class, issues one-hot stage enables and memory/regfile strobes, and owns the PC.
- Sits between the instruction memory, the EX stage ALU/branch unit and the data memory.
- Stops on a halt instruction, an illegal opcode or a memory timeout.

Parameters:
- PC_WIDTH, 64, width of the program counter and branch target.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 16, maximum number of cycles spent waiting in MEMORY for mem_ready before an error halt.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instruction  input  32  instruction memory read data, valid in the FETCH state.
- branch_taken  input  1  branch outcome from EX, valid in the EXECUTE state.
- branch_target  input  PC_WIDTH  branch target from EX, valid in the EXECUTE state.
- mem_ready  input  1  data memory completion, sampled in the MEMORY state.
- pc  output  PC_WIDTH  current fetch address.
- ir  output  32  latched instruction register.
- state  output  3  FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- if_en, id_en, ex_en, mem_en, wb_en  output  1 each  one-hot stage enables.
- mem_read, mem_write  output  1 each  data memory strobes.
- reg_write  output  1  register file write strobe.
- halted  output  1  high in the HALT state.
- err  output  2  halt cause: 0=clean halt, 1=illegal opcode, 2=memory timeout.
- retired  output  CNT_WIDTH  count of completed instructions.

Behaviour:
- Reset (clk edge with reset=1):
  - state=FETCH, pc=RESET_PC, ir=0, retired=0, err=0, wait counter=0.
  - Reset overrides any state, including a MEMORY wait or HALT.
- Outputs are Moore, decoded from state and ir:
  - if_en=(FETCH); id_en=(DECODE); ex_en=(EXECUTE); mem_en=(MEMORY); wb_en=(WRITEBACK).
  - mem_read = MEMORY and load; mem_write = MEMORY and store.
  - reg_write = WRITEBACK; halted = HALT.
  - After reset, only if_en=1 and all other strobes are 0.
- FETCH: ir <= instruction, then go to DECODE.
- DECODE classifies ir[6:0]:
  - ir==0 → HALT with err=0.
  - 0110011 (R-type), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch) → EXECUTE.
  - Any other opcode → HALT with err=1.
- EXECUTE:
  - R-type / I-ALU → WRITEBACK.
  - load / store → MEMORY, wait counter cleared.
  - branch → FETCH; pc <= branch_taken ? branch_target : pc+4; retired += 1.
- MEMORY:
  - If mem_ready=1: load → WRITEBACK; store → FETCH with pc <= pc+4 and retired += 1.
  - If mem_ready=0: wait counter += 1.
  - If the counter reaches MEM_TIMEOUT-1 with mem_ready still 0 → HALT with err=2; pc is not advanced.
  - mem_ready=1 on the final allowed cycle wins over the timeout.
- WRITEBACK → FETCH; pc <= pc+4; retired += 1.
- HALT is absorbing. Only reset exits it; pc, ir and retired are frozen.
- Arithmetic:
  - pc+4 wraps modulo 2^PC_WIDTH.
  - retired wraps to 0 at all-ones.
  - branch_taken and branch_target are ignored outside EXECUTE of a branch.
  - ALU overflow has no effect on sequencing.
- Latency in cycles from FETCH to the next FETCH:
  - R-type / I-ALU: 4.
  - branch: 3.
  - store: 4 + number of mem_ready=0 cycles.
  - load: 5 + number of mem_ready=0 cycles.

Test Plan:
- Reset, then feed R-type ADD 0x002081B3 → states 0,1,2,4,0; reg_write pulses 1 cycle in WB; pc=4; retired=1 after 4 cycles.
- Branch 0x00208463 with branch_taken=1, branch_target=0x100 → states 0,1,2,0; pc=0x100; no wb_en or reg_write; retired=1.
- Load 0x0000B183 with mem_ready low for 3 cycles, then high → mem_read high for 4 cycles, then WB; total 8 cycles; pc=4.
- Store 0x0030B023 with mem_ready never asserted (MEM_TIMEOUT=16) → HALT after 16 MEMORY cycles; err=2; pc unchanged; retired unchanged.
- Opcode 0x0000007F → HALT from DECODE with err=1. Instruction 0x00000000 → HALT with err=0; halted stays 1 for 20 further cycles.
- Assert reset mid-MEMORY wait and again during HALT → next cycle state=FETCH, pc=RESET_PC, retired=0, err=0, all strobes except if_en low.

Source files
------------

// File: rtl/seq_stage_controller.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the sequential RV64 core.
// Owns the PC, the instruction register, the retired counter and the halt cause.
module seq_stage_controller #(
    parameter int unsigned            PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter int unsigned            CNT_WIDTH   = 32,
    parameter int unsigned            MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instruction,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 mem_ready,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [31:0]          ir,
    output logic [2:0]           state,
    output logic                 if_en,
    output logic                 id_en,
    output logic                 ex_en,
    output logic                 mem_en,
    output logic                 wb_en,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 halted,
    output logic [1:0]           err,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int unsigned WAIT_WIDTH = $clog2(MEM_TIMEOUT) + 1;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } stage_t;

    stage_t                cur_state, next_state;
    logic [PC_WIDTH-1:0]   pc_r, pc_next;
    logic [31:0]           ir_r;
    logic [CNT_WIDTH-1:0]  retired_r;
    logic [1:0]            err_r, err_next;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  load_ir, pc_load, retire, set_err, clr_wait, inc_wait;
    logic [6:0]            opcode;
    logic                  is_load, is_store;

    assign opcode   = ir_r[6:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= '0;
            retired_r <= '0;
            err_r     <= '0;
            wait_cnt  <= '0;
        end else begin
            cur_state <= next_state;
            if (load_ir) ir_r      <= instruction;
            if (pc_load) pc_r      <= pc_next;
            if (retire)  retired_r <= retired_r + CNT_WIDTH'(1);
            if (set_err) err_r     <= err_next;
            if (clr_wait)      wait_cnt <= '0;
            else if (inc_wait) wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
        end
    end

    always_comb begin
        next_state = cur_state;
        pc_next    = pc_r + PC_WIDTH'(4);
        err_next   = '0;
        load_ir    = 1'b0;
        pc_load    = 1'b0;
        retire     = 1'b0;
        set_err    = 1'b0;
        clr_wait   = 1'b0;
        inc_wait   = 1'b0;
        unique case (cur_state)
            FETCH: begin
                load_ir    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                if (ir_r == '0) begin
                    next_state = HALT;
                    set_err    = 1'b1;
                end else if (opcode inside {OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH}) begin
                    next_state = EXECUTE;
                end else begin
                    next_state = HALT;
                    set_err    = 1'b1;
                    err_next   = 2'd1;
                end
            end
            EXECUTE: begin
                if (is_load || is_store) begin
                    next_state = MEMORY;
                    clr_wait   = 1'b1;
                end else if (opcode == OP_BRANCH) begin
                    next_state = FETCH;
                    pc_load    = 1'b1;
                    retire     = 1'b1;
                    if (branch_taken) pc_next = branch_target;
                end else begin
                    next_state = WRITEBACK;
                end
            end
            MEMORY: begin
                // A ready on the last allowed wait cycle takes priority over the timeout.
                if (mem_ready) begin
                    if (is_load) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FETCH;
                        pc_load    = 1'b1;
                        retire     = 1'b1;
                    end
                end else if (wait_cnt == WAIT_WIDTH'(MEM_TIMEOUT - 1)) begin
                    next_state = HALT;
                    set_err    = 1'b1;
                    err_next   = 2'd2;
                end else begin
                    inc_wait = 1'b1;
                end
            end
            WRITEBACK: begin
                next_state = FETCH;
                pc_load    = 1'b1;
                retire     = 1'b1;
            end
            HALT:    next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    assign pc        = pc_r;
    assign ir        = ir_r;
    assign state     = cur_state;
    assign err       = err_r;
    assign retired   = retired_r;
    assign if_en     = (cur_state == FETCH);
    assign id_en     = (cur_state == DECODE);
    assign ex_en     = (cur_state == EXECUTE);
    assign mem_en    = (cur_state == MEMORY);
    assign wb_en     = (cur_state == WRITEBACK);
    assign mem_read  = (cur_state == MEMORY) && is_load;
    assign mem_write = (cur_state == MEMORY) && is_store;
    assign reg_write = (cur_state == WRITEBACK);
    assign halted    = (cur_state == HALT);

endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized bench for seq_stage_controller: each instruction is turned into its
// expected per-cycle stage list and architectural effect, then compared cycle by cycle.
module tb_seq_stage_controller;

    localparam int unsigned PW = 64;
    localparam int unsigned CW = 4;
    localparam int unsigned MT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instruction;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic          mem_ready;
    logic [PW-1:0] pc;
    logic [31:0]   ir;
    logic [2:0]    state;
    logic          if_en, id_en, ex_en, mem_en, wb_en;
    logic          mem_read, mem_write, reg_write, halted;
    logic [1:0]    err;
    logic [CW-1:0] retired;

    seq_stage_controller #(
        .PC_WIDTH   (PW),
        .RESET_PC   ('0),
        .CNT_WIDTH  (CW),
        .MEM_TIMEOUT(MT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .mem_ready    (mem_ready),
        .pc           (pc),
        .ir           (ir),
        .state        (state),
        .if_en        (if_en),
        .id_en        (id_en),
        .ex_en        (ex_en),
        .mem_en       (mem_en),
        .wb_en        (wb_en),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .halted       (halted),
        .err          (err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // Instruction classes as the bench sees them.
    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3, C_ZERO = 4, C_ILLEGAL = 5;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    logic [PW-1:0] m_pc;
    logic [31:0]   m_ir;
    logic [CW-1:0] m_ret;
    logic [1:0]    m_err;
    bit            fix_branch = 1'b0;
    logic          fix_bt;
    logic [PW-1:0] fix_tgt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] i);
        if (i == 32'd0) return C_ZERO;
        case (i[6:0])
            7'b0110011, 7'b0010011: return C_ALU;
            7'b0000011:             return C_LOAD;
            7'b0100011:             return C_STORE;
            7'b1100011:             return C_BRANCH;
            default:                return C_ILLEGAL;
        endcase
    endfunction

    task automatic check_cycle(input string tag, input int st, input int cls);
        logic [8:0] exp_vec;
        exp_vec = {st == 0, st == 1, st == 2, st == 3, st == 4,
                   st == 3 && cls == C_LOAD, st == 3 && cls == C_STORE, st == 4, st == 5};
        check({tag, "_state"}, 64'(state), 64'(st));
        check({tag, "_strobes"},
              64'({if_en, id_en, ex_en, mem_en, wb_en, mem_read, mem_write, reg_write, halted}),
              64'(exp_vec));
        check({tag, "_err"}, 64'(err), 64'(m_err));
    endtask

    task automatic randomize_inputs();
        logic [31:0] r1, r2;
        r1 = $urandom; r2 = $urandom;
        instruction   = $urandom;
        branch_taken  = 1'($urandom_range(0, 1));
        branch_target = {r1, r2};
        mem_ready     = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        randomize_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        m_pc = '0; m_ir = '0; m_ret = '0; m_err = 2'd0;
        check_cycle("rst", 0, C_ALU);
        check("rst_pc", pc, m_pc);
        check("rst_ir", 64'(ir), 64'(m_ir));
        check("rst_retired", 64'(retired), 64'(m_ret));
    endtask

    // Called at #1 after an edge with the DUT in FETCH. stalls = mem_ready=0 cycles in MEMORY.
    task automatic run_instr(input logic [31:0] instr, input int stalls, input bit never_ready,
                             input int abort_idx);
        int            cls;
        int            exp_q[$];
        bit            timeout;
        logic          bt;
        logic [PW-1:0] btgt;
        cls     = classify(instr);
        timeout = never_ready && (cls == C_LOAD || cls == C_STORE);
        bt      = 1'b0;
        btgt    = '0;
        exp_q   = '{0, 1};
        if (cls <= C_BRANCH) exp_q.push_back(2);
        if (cls == C_LOAD || cls == C_STORE) begin
            for (int k = 0; k < (timeout ? MT : stalls + 1); k++) exp_q.push_back(3);
        end
        if (!timeout && (cls == C_ALU || cls == C_LOAD)) exp_q.push_back(4);

        for (int idx = 0; idx < exp_q.size(); idx++) begin
            if (idx == abort_idx) return;
            check_cycle("cyc", exp_q[idx], cls);
            randomize_inputs();
            if (idx == 0) instruction = instr;
            if (idx == 2 && fix_branch) begin
                branch_taken  = fix_bt;
                branch_target = fix_tgt;
            end
            if (idx == 2) begin
                bt   = branch_taken;
                btgt = branch_target;
            end
            if (exp_q[idx] == 3) mem_ready = !never_ready && (idx - 3 >= stalls);
            @(posedge clk); #1;
        end

        m_ir = instr;
        if (timeout) m_err = 2'd2;
        else if (cls == C_ZERO) m_err = 2'd0;
        else if (cls == C_ILLEGAL) m_err = 2'd1;
        else begin
            m_pc  = (cls == C_BRANCH && bt) ? btgt : m_pc + 64'd4;
            m_ret = m_ret + 1'b1;
        end
        check("end_state", 64'(state), (timeout || cls >= C_ZERO) ? 64'd5 : 64'd0);
        check("end_pc", pc, m_pc);
        check("end_ir", 64'(ir), 64'(m_ir));
        check("end_retired", 64'(retired), 64'(m_ret));
        check("end_err", 64'(err), 64'(m_err));
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle("halt", 5, C_ILLEGAL);
            check("halt_pc", pc, m_pc);
            check("halt_ir", 64'(ir), 64'(m_ir));
            check("halt_retired", 64'(retired), 64'(m_ret));
            randomize_inputs();
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] gen_instr(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            C_ALU:    return {r[31:7], (r[0] ? 7'b0110011 : 7'b0010011)};
            C_LOAD:   return {r[31:7], 7'b0000011};
            C_STORE:  return {r[31:7], 7'b0100011};
            C_BRANCH: return {r[31:7], 7'b1100011};
            C_ZERO:   return 32'd0;
            default: begin
                while (classify(r) != C_ILLEGAL) r = $urandom;
                return r;
            end
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        randomize_inputs();
        @(posedge clk); #1;
        do_reset();

        run_instr(32'h002081B3, 0, 1'b0, -1);
        fix_branch = 1'b1; fix_bt = 1'b1; fix_tgt = 64'h100;
        run_instr(32'h00208463, 0, 1'b0, -1);
        fix_branch = 1'b0;
        run_instr(32'h0000B183, 3, 1'b0, -1);
        run_instr(32'h0030B023, MT - 1, 1'b0, -1);
        fix_branch = 1'b1; fix_bt = 1'b1; fix_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        run_instr(32'h00008063, 0, 1'b0, -1);
        fix_branch = 1'b0;
        run_instr(32'h00000013, 0, 1'b0, -1);

        run_instr(32'h0030B023, 0, 1'b1, -1);
        halt_hold(5);
        do_reset();
        run_instr(32'h0000007F, 0, 1'b0, -1);
        halt_hold(3);
        do_reset();
        run_instr(32'h00000000, 0, 1'b0, -1);
        halt_hold(20);
        do_reset();
        run_instr(32'h0030B023, 10, 1'b0, 8);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            int cls;
            int pick;
            bit never;
            pick  = $urandom_range(0, 99);
            cls   = pick < 30 ? C_ALU : pick < 50 ? C_LOAD : pick < 70 ? C_STORE :
                    pick < 92 ? C_BRANCH : pick < 95 ? C_ZERO : C_ILLEGAL;
            never = ($urandom_range(0, 19) == 0);
            run_instr(gen_instr(cls), $urandom_range(0, MT - 1), never, -1);
            if (halted) begin
                halt_hold($urandom_range(1, 4));
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
